// File: rtl/hot_addr_pkg.sv
package hot_addr_pkg;

  localparam int HOT_ADDR_SIZE = 33;

  typedef logic [HOT_ADDR_SIZE-1:0] pfn_t;

  localparam pfn_t HOT_PFN_INVALID = '1;

  typedef enum logic [2:0] {
    DROP_NONE,
    DROP_INV,
    DROP_RANGE,
    DROP_DUP,
    DROP_FULL
  } drop_reason_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hot_addr_dup_filter.sv
module hot_addr_dup_filter
  import hot_addr_pkg::*;
#(
  parameter int ADDR_SIZE = HOT_ADDR_SIZE,
  parameter int ENTRIES   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [ADDR_SIZE-1:0] lookup_addr,
  output logic                 hit,
  input  logic                 ins_en,
  input  logic [ADDR_SIZE-1:0] ins_addr
);

  localparam int PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [ADDR_SIZE-1:0] entry [ENTRIES];
  logic [ENTRIES-1:0]   valid;
  logic [PW-1:0]        wr_ptr;

  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (valid[i] && (entry[i] == lookup_addr)) begin
        hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid  <= '0;
      wr_ptr <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        entry[i] <= '0;
      end
    end else if (clr) begin
      valid  <= '0;
      wr_ptr <= '0;
    end else if (ins_en) begin
      entry[wr_ptr] <= ins_addr;
      valid[wr_ptr] <= 1'b1;
      wr_ptr        <= wr_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/hot_addr_ingress_queue.sv
module hot_addr_ingress_queue
  import hot_addr_pkg::*;
#(
  parameter int ADDR_SIZE      = HOT_ADDR_SIZE,
  parameter int DEPTH          = 32,
  parameter int FILTER_ENTRIES = 8
) (
  input  logic                       axi4_mm_clk,
  input  logic                       axi4_mm_rst,
  input  logic                       trk_valid,
  input  logic [ADDR_SIZE-1:0]       trk_addr,
  input  logic [32:0]                csr_addr_lb,
  input  logic [32:0]                csr_addr_ub,
  input  logic                       csr_flush,
  output logic                       page_mig_addr_en,
  output logic [ADDR_SIZE-1:0]       page_mig_addr,
  input  logic                       page_mig_addr_ready,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic [31:0]                push_cnt,
  output logic [31:0]                drop_dup_cnt,
  output logic [31:0]                drop_range_cnt,
  output logic [31:0]                drop_full_cnt,
  output logic [31:0]                drop_inv_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (ADDR_SIZE > 33) ? ADDR_SIZE : 33;

  logic                 s0_valid;
  logic [ADDR_SIZE-1:0] s0_addr;

  logic [ADDR_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;

  logic                 pop;
  logic                 full;
  logic                 hit;
  logic                 s1_push;
  drop_reason_t         reason;

  logic [CW-1:0]        addr_ext;
  logic [CW-1:0]        lb_ext;
  logic [CW-1:0]        ub_ext;

  assign addr_ext = CW'(s0_addr);
  assign lb_ext   = CW'(csr_addr_lb);
  assign ub_ext   = CW'(csr_addr_ub);

  assign page_mig_addr_en = (count != '0);
  assign page_mig_addr    = mem[rd_ptr];
  assign fill_level       = count;
  assign pop              = page_mig_addr_en && page_mig_addr_ready;
  assign full             = (count == (AW+1)'(DEPTH));

  always_ff @(posedge axi4_mm_clk or posedge axi4_mm_rst) begin
    if (axi4_mm_rst) begin
      s0_valid <= 1'b0;
      s0_addr  <= '0;
    end else begin
      s0_valid <= trk_valid && !csr_flush;
      s0_addr  <= trk_addr;
    end
  end

  // The flush-cycle S1 word is neither pushed nor counted.
  always_comb begin
    reason  = DROP_NONE;
    s1_push = 1'b0;
    if (s0_valid && !csr_flush) begin
      if (s0_addr == '1) begin
        reason = DROP_INV;
      end else if ((addr_ext < lb_ext) || (addr_ext > ub_ext)) begin
        reason = DROP_RANGE;
      end else if (hit) begin
        reason = DROP_DUP;
      end else if (full && !pop) begin
        reason = DROP_FULL;
      end else begin
        s1_push = 1'b1;
      end
    end
  end

  hot_addr_dup_filter #(
    .ADDR_SIZE (ADDR_SIZE),
    .ENTRIES   (FILTER_ENTRIES)
  ) u_filter (
    .clk         (axi4_mm_clk),
    .rst         (axi4_mm_rst),
    .clr         (csr_flush),
    .lookup_addr (s0_addr),
    .hit         (hit),
    .ins_en      (s1_push),
    .ins_addr    (s0_addr)
  );

  always_ff @(posedge axi4_mm_clk or posedge axi4_mm_rst) begin
    if (axi4_mm_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (csr_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (s1_push) begin
        mem[wr_ptr] <= s0_addr;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + {{AW{1'b0}}, s1_push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge axi4_mm_clk or posedge axi4_mm_rst) begin
    if (axi4_mm_rst) begin
      push_cnt       <= '0;
      drop_dup_cnt   <= '0;
      drop_range_cnt <= '0;
      drop_full_cnt  <= '0;
      drop_inv_cnt   <= '0;
    end else begin
      if (s1_push) begin
        push_cnt <= sat_inc(push_cnt);
      end
      unique case (reason)
        DROP_INV:   drop_inv_cnt   <= sat_inc(drop_inv_cnt);
        DROP_RANGE: drop_range_cnt <= sat_inc(drop_range_cnt);
        DROP_DUP:   drop_dup_cnt   <= sat_inc(drop_dup_cnt);
        DROP_FULL:  drop_full_cnt  <= sat_inc(drop_full_cnt);
        default:    ;
      endcase
    end
  end

endmodule

// File: tb/tb_hot_addr_ingress_queue.sv
module tb_hot_addr_ingress_queue;

  localparam int AS    = 33;
  localparam int DEPTH = 32;
  localparam int FE    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          trk_valid;
  logic [AS-1:0] trk_addr;
  logic [32:0]   lb, ub;
  logic          flush;
  logic          en;
  logic [AS-1:0] head;
  logic          ready;
  logic [5:0]    fill_level;
  logic [31:0]   push_cnt, drop_dup_cnt, drop_range_cnt, drop_full_cnt, drop_inv_cnt;

  always #5 clk = ~clk;

  hot_addr_ingress_queue #(
    .ADDR_SIZE      (AS),
    .DEPTH          (DEPTH),
    .FILTER_ENTRIES (FE)
  ) dut (
    .axi4_mm_clk         (clk),
    .axi4_mm_rst         (rst),
    .trk_valid           (trk_valid),
    .trk_addr            (trk_addr),
    .csr_addr_lb         (lb),
    .csr_addr_ub         (ub),
    .csr_flush           (flush),
    .page_mig_addr_en    (en),
    .page_mig_addr       (head),
    .page_mig_addr_ready (ready),
    .fill_level          (fill_level),
    .push_cnt            (push_cnt),
    .drop_dup_cnt        (drop_dup_cnt),
    .drop_range_cnt      (drop_range_cnt),
    .drop_full_cnt       (drop_full_cnt),
    .drop_inv_cnt        (drop_inv_cnt)
  );

  int tests = 0;
  int fails = 0;
  bit mon_on = 1'b0;

  // Reference model: FIFO occupancy, expected delivery order, last FE accepted PFNs.
  logic [AS-1:0] exp_q [$];
  logic [AS-1:0] recent [$];
  int            m_cnt;
  bit            m_s0v;
  logic [AS-1:0] m_s0a;
  int unsigned   m_push, m_dup, m_rng, m_full, m_inv;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit in_recent(input logic [AS-1:0] a);
    foreach (recent[i]) if (recent[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    recent.delete();
    m_cnt = 0; m_s0v = 1'b0; m_s0a = '0;
    m_push = 0; m_dup = 0; m_rng = 0; m_full = 0; m_inv = 0;
  endtask

  // Predicts the effect of the upcoming clock edge from the current inputs.
  task automatic model_step();
    bit pop, acc;
    if (rst) return;
    pop = (m_cnt > 0) && ready;
    acc = 1'b0;
    if (flush) begin
      m_cnt = 0;
      exp_q.delete();
      recent.delete();
      m_s0v = 1'b0;
      m_s0a = trk_addr;
      return;
    end
    if (m_s0v) begin
      if (m_s0a == {AS{1'b1}}) m_inv++;
      else if (m_s0a < lb || m_s0a > ub) m_rng++;
      else if (in_recent(m_s0a)) m_dup++;
      else if (m_cnt == DEPTH && !pop) m_full++;
      else begin
        acc = 1'b1;
        m_push++;
        exp_q.push_back(m_s0a);
        recent.push_back(m_s0a);
        if (recent.size() > FE) void'(recent.pop_front());
      end
    end
    m_cnt = m_cnt + int'(acc) - int'(pop);
    m_s0v = trk_valid;
    m_s0a = trk_addr;
  endtask

  // Monitor: compares the output interface against the scoreboard on every falling edge.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("fill_level", 64'(fill_level), 64'(m_cnt));
      chk("en", 64'(en), 64'(m_cnt != 0));
      if (en) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL head_unexpected: got 0x%0h, expected no entry (t=%0t)", head, $time);
        end else begin
          chk("head", 64'(head), 64'(exp_q[0]));
          if (ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic cycle();
    @(negedge clk);
    #1;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [AS-1:0] a);
    trk_valid = 1'b1;
    trk_addr  = a;
    cycle();
  endtask

  task automatic idle(input int n);
    trk_valid = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic check_counters();
    chk("push_cnt", 64'(push_cnt), 64'(m_push));
    chk("drop_dup_cnt", 64'(drop_dup_cnt), 64'(m_dup));
    chk("drop_range_cnt", 64'(drop_range_cnt), 64'(m_rng));
    chk("drop_full_cnt", 64'(drop_full_cnt), 64'(m_full));
    chk("drop_inv_cnt", 64'(drop_inv_cnt), 64'(m_inv));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_en"}, 64'(en), 64'd0);
    chk({tag, "_addr"}, 64'(head), 64'd0);
    chk({tag, "_fill"}, 64'(fill_level), 64'd0);
    chk({tag, "_cnts"}, 64'(push_cnt | drop_dup_cnt | drop_range_cnt | drop_full_cnt | drop_inv_cnt), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; trk_valid = 1'b0; trk_addr = '0; flush = 1'b0; ready = 1'b0;
    lb = '0; ub = '1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    mon_on = 1'b1;

    // Single PFN latency
    ready = 1'b1;
    send(33'h1234);
    chk("lat_early_en", 64'(en), 64'd0);
    trk_valid = 1'b0;
    cycle();
    chk("lat_en", 64'(en), 64'd1);
    chk("lat_addr", 64'(head), 64'h1234);
    cycle();
    chk("lat_en_after_pop", 64'(en), 64'd0);
    chk("single_push_cnt", 64'(push_cnt), 64'd1);

    // Duplicate filter and eviction
    send(33'h10); send(33'h10); send(33'h11); send(33'h10);
    idle(3);
    chk("dup_cnt", 64'(drop_dup_cnt), 64'd2);
    for (int i = 0; i < 8; i++) send(33'h20 + 33'(i));
    send(33'h10);
    idle(4);
    chk("evict_push_cnt", 64'(push_cnt), 64'd12);
    chk("evict_dup_cnt", 64'(drop_dup_cnt), 64'd2);
    check_counters();

    // Window and invalid marker
    lb = 33'h100; ub = 33'h1FF;
    send(33'hFF); send(33'h100); send(33'h1FF); send(33'h200); send('1);
    idle(3);
    chk("range_cnt", 64'(drop_range_cnt), 64'd2);
    chk("inv_cnt", 64'(drop_inv_cnt), 64'd1);
    chk("window_push_cnt", 64'(push_cnt), 64'd14);
    lb = '0; ub = '1;

    // Overflow, full-with-pop, drain
    ready = 1'b0;
    for (int i = 0; i < 40; i++) send(33'h1000 + 33'(i));
    idle(2);
    chk("ovf_fill", 64'(fill_level), 64'd32);
    chk("ovf_full_cnt", 64'(drop_full_cnt), 64'd8);
    send(33'h2000);
    ready = 1'b1;
    trk_valid = 1'b0;
    cycle();
    chk("full_pop_fill", 64'(fill_level), 64'd32);
    chk("full_pop_full_cnt", 64'(drop_full_cnt), 64'd8);
    idle(40);
    chk("drain_fill", 64'(fill_level), 64'd0);
    check_counters();

    // Flush
    ready = 1'b0;
    for (int i = 0; i < 5; i++) send(33'h3000 + 33'(i));
    idle(2);
    chk("pre_flush_fill", 64'(fill_level), 64'd5);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_en", 64'(en), 64'd0);
    chk("flush_fill", 64'(fill_level), 64'd0);
    ready = 1'b1;
    send(33'h3000);
    idle(3);
    check_counters();

    // Randomized traffic
    for (int seg = 0; seg < 8; seg++) begin
      int unsigned rdy_pct;
      rdy_pct = $urandom_range(10, 100);
      if (seg % 2 == 1) begin
        lb = 33'($urandom_range(0, 20));
        ub = 33'($urandom_range(30, 60));
      end else begin
        lb = '0; ub = '1;
      end
      for (int c = 0; c < 200; c++) begin
        int unsigned sel;
        sel = $urandom_range(0, 99);
        trk_valid = ($urandom_range(0, 3) != 0);
        if (sel < 8) trk_addr = '1;
        else if (sel < 14) trk_addr = {1'b0, 32'($urandom)};
        else trk_addr = 33'($urandom_range(0, 60));
        ready = ($urandom_range(1, 100) <= rdy_pct);
        flush = ($urandom_range(0, 99) == 0);
        cycle();
      end
      flush = 1'b0;
      ready = 1'b1;
      idle(4);
      check_counters();
    end
    lb = '0; ub = '1;
    idle(40);

    // Asynchronous reset mid-stream
    ready = 1'b0;
    for (int i = 0; i < 10; i++) send(33'h5000 + 33'(i));
    idle(2);
    chk("pre_rst_fill", 64'(fill_level), 64'd10);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_zero("async_rst");
    trk_valid = 1'b0;
    cycle();
    rst = 1'b0;
    ready = 1'b1;
    send(33'h1234);
    idle(4);
    chk("post_rst_push_cnt", 64'(push_cnt), 64'd1);
    check_counters();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
